// File: rtl/pattern_loader_pkg.sv
// rtl/pattern_loader_pkg.sv - shared states, constants and pattern word helper for pattern_loader
package pattern_loader_pkg;

   // Default register map geometry; the loader's parameters default to these.
   localparam int PL_REG_WIDTH  = 32;
   localparam int PL_REG_DEPTH  = 4;
   localparam int PL_PAT_WIDTH  = PL_REG_DEPTH - 1;
   localparam int PL_PAT_SIZE   = PL_PAT_WIDTH * PL_REG_WIDTH;
   localparam int PL_RD_TIMEOUT = 16;

   // Control register location and the matcher enable bit inside it.
   localparam int CTRL_ADDR  = 0;
   localparam int ENABLE_BIT = 0;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      DIS  = 3'd1,
      WR   = 3'd2,
      VFY  = 3'd3,
      EN   = 3'd4,
      DONE = 3'd5
   } state_e;

   // Key word k (1-based register address) taken from the latched pattern in
   // pattern index order; address 0 is the control register and has no word.
   function automatic logic [PL_REG_WIDTH-1:0] pattern_word(
      input logic [0:PL_PAT_SIZE-1] pat,
      input int unsigned            k
   );
      if (k == 0 || k > PL_PAT_WIDTH) begin
         return '0;
      end
      return pat[(k-1)*PL_REG_WIDTH +: PL_REG_WIDTH];
   endfunction

endpackage

// File: rtl/avalon_mm_if.sv
// rtl/avalon_mm_if.sv - Avalon-MM bus bundle with master and slave views
interface avalon_mm_if #(
   parameter int ADDR_WIDTH = 2,
   parameter int DATA_WIDTH = 32
);
   logic [ADDR_WIDTH-1:0] address;
   logic                  write;
   logic [DATA_WIDTH-1:0] writedata;
   logic                  read;
   logic [DATA_WIDTH-1:0] readdata;
   logic                  readdatavalid;
   logic                  waitrequest;

   modport master (
      output address, write, writedata, read,
      input  readdata, readdatavalid, waitrequest
   );

   modport slave (
      input  address, write, writedata, read,
      output readdata, readdatavalid, waitrequest
   );
endinterface

// File: rtl/pattern_loader.sv
// rtl/pattern_loader.sv - atomic pattern reload master; readback verify built when PATTERN_LOADER_VERIFY_EN is defined
module pattern_loader
   import pattern_loader_pkg::*;
#(
   parameter int REG_WIDTH  = PL_REG_WIDTH,
   parameter int REG_DEPTH  = PL_REG_DEPTH,
   parameter int PAT_WIDTH  = REG_DEPTH - 1,
   parameter int PAT_SIZE   = PAT_WIDTH * REG_WIDTH,
   parameter int ADDR_WIDTH = $clog2(REG_DEPTH),
   parameter int RD_TIMEOUT = PL_RD_TIMEOUT
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                load_req_i,
   input  logic [0:PAT_SIZE-1] pattern_i,
   input  logic                enable_after_i,
   avalon_mm_if.master         amm_master_if,
   output logic                busy_o,
   output logic                done_o,
   output logic                error_o
);

   localparam logic [ADDR_WIDTH-1:0] LAST_WORD = ADDR_WIDTH'(PAT_WIDTH);
   localparam logic [ADDR_WIDTH-1:0] CTRL_A    = ADDR_WIDTH'(CTRL_ADDR);
   localparam logic [REG_WIDTH-1:0]  EN_DATA   = REG_WIDTH'(1) << ENABLE_BIT;

   state_e                 state_q, state_d;
   logic [0:PAT_SIZE-1]    pat_q, pat_d;
   logic                   en_after_q, en_after_d;
   logic [ADDR_WIDTH-1:0]  word_q, word_d;
   logic                   err_q, err_d;

   logic                   cmd_wr, cmd_rd;
   logic [ADDR_WIDTH-1:0]  cmd_addr;
   logic [REG_WIDTH-1:0]   cmd_data;
   logic [REG_WIDTH-1:0]   cur_word;

`ifdef PATTERN_LOADER_VERIFY_EN
   localparam int TMO_W = $clog2(RD_TIMEOUT + 1);
   logic                   rd_pend_q, rd_pend_d;
   logic [TMO_W-1:0]       tmo_q, tmo_d;
   logic                   rd_done;
`else
   localparam int unused_rd_timeout = RD_TIMEOUT;
   logic unused_rd;
   assign unused_rd = ^{amm_master_if.readdata, amm_master_if.readdatavalid};
`endif

   assign cur_word = pattern_word(pat_q, 32'(word_q));

   // State, latched request and counters; reset abandons any in-flight command.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         pat_q      <= '0;
         en_after_q <= 1'b0;
         word_q     <= '0;
         err_q      <= 1'b0;
`ifdef PATTERN_LOADER_VERIFY_EN
         rd_pend_q  <= 1'b0;
         tmo_q      <= '0;
`endif
      end else begin
         state_q    <= state_d;
         pat_q      <= pat_d;
         en_after_q <= en_after_d;
         word_q     <= word_d;
         err_q      <= err_d;
`ifdef PATTERN_LOADER_VERIFY_EN
         rd_pend_q  <= rd_pend_d;
         tmo_q      <= tmo_d;
`endif
      end
   end

   // Sequence control and bus command generation; commands hold while waitrequest is high.
   always_comb begin
      state_d    = state_q;
      pat_d      = pat_q;
      en_after_d = en_after_q;
      word_d     = word_q;
      err_d      = err_q;
      cmd_wr     = 1'b0;
      cmd_rd     = 1'b0;
      cmd_addr   = '0;
      cmd_data   = '0;
`ifdef PATTERN_LOADER_VERIFY_EN
      rd_pend_d  = rd_pend_q;
      tmo_d      = tmo_q;
      rd_done    = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (load_req_i) begin
               pat_d      = pattern_i;
               en_after_d = enable_after_i;
               err_d      = 1'b0;
               word_d     = '0;
               state_d    = DIS;
            end
         end
         DIS: begin
            cmd_wr   = 1'b1;
            cmd_addr = CTRL_A;
            if (!amm_master_if.waitrequest) begin
               word_d  = ADDR_WIDTH'(1);
               state_d = WR;
            end
         end
         WR: begin
            cmd_wr   = 1'b1;
            cmd_addr = word_q;
            cmd_data = cur_word;
            if (!amm_master_if.waitrequest) begin
               if (word_q == LAST_WORD) begin
`ifdef PATTERN_LOADER_VERIFY_EN
                  word_d    = ADDR_WIDTH'(1);
                  rd_pend_d = 1'b0;
                  tmo_d     = '0;
                  state_d   = VFY;
`else
                  state_d   = en_after_q ? EN : DONE;
`endif
               end else begin
                  word_d = word_q + ADDR_WIDTH'(1);
               end
            end
         end
`ifdef PATTERN_LOADER_VERIFY_EN
         VFY: begin
            cmd_rd   = !rd_pend_q;
            cmd_addr = word_q;
            if (!rd_pend_q) begin
               // Data may come back in the same cycle the read is accepted.
               if (!amm_master_if.waitrequest) begin
                  if (amm_master_if.readdatavalid) begin
                     rd_done = 1'b1;
                  end else begin
                     rd_pend_d = 1'b1;
                     tmo_d     = '0;
                  end
               end
            end else if (amm_master_if.readdatavalid) begin
               rd_done = 1'b1;
            end else if (tmo_q == TMO_W'(RD_TIMEOUT - 1)) begin
               err_d   = 1'b1;
               state_d = DONE;
            end else begin
               tmo_d = tmo_q + TMO_W'(1);
            end
            if (rd_done) begin
               rd_pend_d = 1'b0;
               if (amm_master_if.readdata != cur_word) begin
                  err_d   = 1'b1;
                  state_d = DONE;
               end else if (word_q == LAST_WORD) begin
                  state_d = en_after_q ? EN : DONE;
               end else begin
                  word_d = word_q + ADDR_WIDTH'(1);
               end
            end
         end
`endif
         EN: begin
            cmd_wr   = 1'b1;
            cmd_addr = CTRL_A;
            cmd_data = EN_DATA;
            if (!amm_master_if.waitrequest) begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign amm_master_if.write     = cmd_wr;
   assign amm_master_if.read      = cmd_rd;
   assign amm_master_if.address   = cmd_addr;
   assign amm_master_if.writedata = cmd_data;

   assign busy_o  = (state_q != IDLE);
   assign done_o  = (state_q == DONE);
   assign error_o = (state_q == DONE) && err_q;

endmodule

// File: tb/tb_pattern_loader.sv
// tb/tb_pattern_loader.sv - self-checking bench for pattern_loader with an Avalon-MM slave model
module tb_pattern_loader;

   localparam int RD_TIMEOUT = 16;
`ifdef PATTERN_LOADER_VERIFY_EN
   localparam bit VFY_ON = 1'b1;
`else
   localparam bit VFY_ON = 1'b0;
`endif

   typedef struct {
      bit          wr;
      int          addr;
      logic [31:0] data;
   } xfer_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        req;
   logic [0:95] pattern;
   logic        en_after;
   logic        busy, done, err;

   avalon_mm_if #(.ADDR_WIDTH(2), .DATA_WIDTH(32)) amm ();

   pattern_loader dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .load_req_i     (req),
      .pattern_i      (pattern),
      .enable_after_i (en_after),
      .amm_master_if  (amm),
      .busy_o         (busy),
      .done_o         (done),
      .error_o        (err)
   );

   always #5 clk = ~clk;

   // Slave model controls
   int          wait_n = 0;
   bit          corrupt_en = 0;
   int          corrupt_addr = 0;
   bit          no_rdv = 0;
   bit          clr_req = 0;

   // Slave and monitor state
   logic [31:0] regs [4];
   int          ws_cnt = 0;
   int          cyc = 0;
   int          done_cnt = 0, err_cnt = 0, done_cyc = 0;
   int          lone_err = 0, both_cnt = 0, stab_viol = 0;
   bit          hold_v = 0;
   logic        h_wr, h_rd;
   logic [1:0]  h_addr;
   logic [31:0] h_data;
   xfer_t       log_q[$];
   xfer_t       exp_q[$];
   int          exp_err_g;

   logic cmd;
   assign cmd               = amm.write | amm.read;
   assign amm.waitrequest   = cmd && (ws_cnt < wait_n);
   assign amm.readdatavalid = amm.read && !amm.waitrequest && !no_rdv;
   assign amm.readdata      = regs[amm.address] ^
                              ((corrupt_en && amm.address == 2'(corrupt_addr)) ? 32'h0000_0100 : 32'h0);

   always @(posedge clk) cyc <= cyc + 1;

   // Slave register file, wait-state generator and bus protocol monitor
   always @(posedge clk or posedge rst) begin
      if (clr_req) begin
         for (int i = 0; i < 4; i++) regs[i] <= 32'h0;
      end
      if (rst) begin
         ws_cnt <= 0;
         hold_v <= 1'b0;
      end else begin
         if (amm.write && amm.read) both_cnt <= both_cnt + 1;
         if (hold_v && (amm.write !== h_wr || amm.read !== h_rd || amm.address !== h_addr ||
                        (h_wr && amm.writedata !== h_data)))
            stab_viol <= stab_viol + 1;
         hold_v <= cmd && amm.waitrequest;
         h_wr   <= amm.write;
         h_rd   <= amm.read;
         h_addr <= amm.address;
         h_data <= amm.writedata;
         if (cmd && amm.waitrequest) begin
            ws_cnt <= ws_cnt + 1;
         end else if (cmd) begin
            ws_cnt <= 0;
            log_q.push_back('{wr: amm.write, addr: int'(amm.address), data: amm.writedata});
            if (amm.write) regs[amm.address] <= amm.writedata;
         end
         if (done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
            if (err) err_cnt <= err_cnt + 1;
         end
         if (err && !done) lone_err <= lone_err + 1;
      end
   end

   int errors = 0;
   int checks = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   function automatic logic [63:0] pack(input xfer_t x);
      return {23'b0, x.wr, 8'(x.addr), (x.wr ? x.data : 32'h0)};
   endfunction

   // Reference: the bus transfers the loader must complete for one load.
   task automatic build_exp(input logic [31:0] w0, w1, w2, input bit ena, input int fail_k, input bit tmo);
      logic [31:0] w [3];
      bit ok;
      w[0] = w0; w[1] = w1; w[2] = w2;
      exp_q.delete();
      ok = 1'b1;
      exp_q.push_back('{wr: 1'b1, addr: 0, data: 32'h0});
      for (int k = 1; k <= 3; k++) exp_q.push_back('{wr: 1'b1, addr: k, data: w[k-1]});
      if (VFY_ON) begin
         for (int k = 1; k <= 3; k++) begin
            exp_q.push_back('{wr: 1'b0, addr: k, data: 32'h0});
            if (tmo || k == fail_k) begin
               ok = 1'b0;
               break;
            end
         end
      end
      if (ok && ena) exp_q.push_back('{wr: 1'b1, addr: 0, data: 32'h1});
      exp_err_g = ok ? 0 : 1;
   endtask

   function automatic int exp_latency(input int n_xfer, input int w, input bit tmo);
      return n_xfer * (1 + w) + (tmo ? RD_TIMEOUT : 0) + 1;
   endfunction

   task automatic wait_done(input int dc);
      for (int i = 0; i < 400 && done_cnt == dc; i++) @(negedge clk);
   endtask

   task automatic check_seq(input string tag, input int base);
      chk({tag, "/count"}, 64'(log_q.size() - base), 64'(exp_q.size()));
      for (int i = 0; i < exp_q.size(); i++) begin
         logic [63:0] obs;
         obs = (base + i < log_q.size()) ? pack(log_q[base + i]) : '1;
         chk($sformatf("%s/xfer%0d", tag, i), obs, pack(exp_q[i]));
      end
   endtask

   task automatic do_load(input string tag, input logic [31:0] w0, w1, w2, input bit ena,
                          input int w, input int fail_k, input bit tmo);
      int base, dc, ec, t0;
      wait_n       = w;
      corrupt_en   = (fail_k != 0);
      corrupt_addr = fail_k;
      no_rdv       = tmo;
      build_exp(w0, w1, w2, ena, fail_k, tmo);
      base = log_q.size(); dc = done_cnt; ec = err_cnt;
      pattern  = {w0, w1, w2};
      en_after = ena;
      req      = 1'b1;
      t0       = cyc;
      @(negedge clk);
      req = 1'b0;
      wait_done(dc);
      chk({tag, "/done"}, 64'(done_cnt - dc), 64'd1);
      chk({tag, "/latency"}, 64'(done_cyc - t0), 64'(exp_latency(exp_q.size(), w, tmo)));
      chk({tag, "/error"}, 64'(err_cnt - ec), 64'(exp_err_g));
      chk({tag, "/busy_after"}, 64'(busy), 64'd0);
      check_seq(tag, base);
      chk({tag, "/wrken"}, 64'(regs[0][0]), 64'(ena && exp_err_g == 0));
      corrupt_en = 0; no_rdv = 0;
   endtask

   initial begin
      int base, dc, t0;
      logic [31:0] a0, a1, a2;
      rst = 1'b1; req = 1'b0; pattern = '0; en_after = 1'b0; clr_req = 1'b1;
      repeat (3) @(negedge clk);
      chk("reset/write", 64'(amm.write), 64'd0);
      chk("reset/read", 64'(amm.read), 64'd0);
      chk("reset/addr_data", {30'b0, amm.address, amm.writedata}, 64'd0);
      chk("reset/busy_done_err", {61'b0, busy, done, err}, 64'd0);
      rst = 1'b0;
      @(negedge clk);
      clr_req = 1'b0;

      do_load("basic", 32'h41424344, 32'h45464748, 32'h494A4B4C, 1'b1, 0, 0, 1'b0);
      do_load("backpressure", $urandom, $urandom, $urandom, 1'b1, 3, 0, 1'b0);
      chk("backpressure/stable", 64'(stab_viol), 64'd0);
      do_load("no_enable", $urandom, $urandom, $urandom, 1'b0, $urandom_range(0, 2), 0, 1'b0);
      for (int i = 0; i < 3; i++)
         do_load($sformatf("rand%0d", i), $urandom, $urandom, $urandom, 1'($urandom_range(0, 1)),
                 $urandom_range(0, 4), 0, 1'b0);
`ifdef PATTERN_LOADER_VERIFY_EN
      do_load("verify_fail", $urandom, $urandom, $urandom, 1'b1, 0, 2, 1'b0);
      do_load("rd_timeout", $urandom, $urandom, $urandom, 1'b1, 0, 0, 1'b1);
`endif

      // Reset while the write to address 2 is on the bus, request held throughout.
      wait_n = 0;
      a0 = $urandom; a1 = $urandom; a2 = $urandom;
      pattern = {a0, a1, a2}; en_after = 1'b1; req = 1'b1;
      for (int i = 0; i < 50 && !(amm.write && amm.address == 2'd2); i++) @(negedge clk);
      chk("rst_mid/found_wr2", 64'(amm.write && amm.address == 2'd2), 64'd1);
      rst = 1'b1;
      #1;
      chk("rst_mid/write_drop", 64'(amm.write), 64'd0);
      chk("rst_mid/busy_drop", 64'(busy), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      build_exp(a0, a1, a2, 1'b1, 0, 1'b0);
      base = log_q.size(); dc = done_cnt; t0 = cyc;
      @(negedge clk);
      req = 1'b0;
      wait_done(dc);
      chk("rst_mid/latency", 64'(done_cyc - t0), 64'(exp_latency(exp_q.size(), 0, 1'b0)));
      check_seq("rst_mid", base);

      // A second request during the writes must not disturb the running load.
      a0 = $urandom; a1 = $urandom; a2 = $urandom;
      build_exp(a0, a1, a2, 1'b1, 0, 1'b0);
      base = log_q.size(); dc = done_cnt;
      pattern = {a0, a1, a2}; en_after = 1'b1; req = 1'b1;
      @(negedge clk);
      req = 1'b0;
      for (int i = 0; i < 50 && !(amm.write && amm.address == 2'd1); i++) @(negedge clk);
      pattern = {~a0, ~a1, ~a2}; en_after = 1'b0; req = 1'b1;
      @(negedge clk);
      req = 1'b0;
      wait_done(dc);
      repeat (5) @(negedge clk);
      chk("busy_req/done_once", 64'(done_cnt - dc), 64'd1);
      check_seq("busy_req", base);

      chk("bus/rd_wr_overlap", 64'(both_cnt), 64'd0);
      chk("bus/stable", 64'(stab_viol), 64'd0);
      chk("bus/err_without_done", 64'(lone_err), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pattern_loader.md
Name: pattern_loader

Overview:
- Avalon-MM master that reprograms the pattern-match control register block atomically.
- On a load request it:
  - disables matching (clears the enable bit at address 0x0),
  - writes the key-symbol words to addresses 0x1..PAT_WIDTH,
  - optionally reads them back for verification,
  - re-enables matching if requested.
- Sits between the host/config logic and the control register slave, so the matcher never runs on a half-written pattern.

Parameters:
- REG_WIDTH, 32, data width of one register / Avalon word.
- REG_DEPTH, 4, number of registers in the slave map (0x0 control + key words).
- PAT_WIDTH, REG_DEPTH-1, number of key-symbol words.
- PAT_SIZE, PAT_WIDTH*REG_WIDTH, total pattern bits.
- ADDR_WIDTH, $clog2(REG_DEPTH), Avalon address width.
- RD_TIMEOUT, 16, maximum cycles to wait for readdatavalid after a read is accepted.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  asynchronous, active-high reset.
- load_req_i  in  1  level request to start a load; sampled only in IDLE.
- pattern_i  in  [0:PAT_SIZE-1]  new pattern; latched on acceptance.
- enable_after_i  in  1  latched with pattern_i; 1 = write enable=1 after loading.
- amm_master_if  avalon_mm_if.master  -  address, write, writedata, read, readdata, readdatavalid, waitrequest.
- busy_o  out  1  high from acceptance until the cycle after done_o.
- done_o  out  1  one-cycle pulse when the sequence ends (success or error).
- error_o  out  1  one-cycle pulse, coincident with done_o, on verify mismatch or read timeout.

Behaviour:
- Reset (async assert, sync to clk_i on release):
  - FSM goes to IDLE.
  - write, read, busy_o, done_o and error_o = 0; address and writedata = 0.
  - Reset mid-sequence drops any in-flight command immediately. Slave contents are not touched by the loader.
- IDLE:
  - if load_req_i = 1: latch pattern_i and enable_after_i, set busy_o next cycle, go to DIS.
  - Requests while busy are ignored; a held request restarts a load only after return to IDLE.
- DIS: write address 0x0, writedata 0.
- WR: write address k = 1..PAT_WIDTH, writedata = pattern word k-1, i.e. latched bits [(k-1)*REG_WIDTH +: REG_WIDTH] in pattern_i index order. Word counter runs 1..PAT_WIDTH.
- VFY (only with the optional feature): per word k:
  - read address k;
  - once the read is accepted, wait for readdatavalid, which may arrive in the acceptance cycle;
  - compare readdata with word k-1.
- EN: entered only if enable_after latched as 1; write address 0x0, writedata 1. Otherwise skipped.
- DONE: one cycle; done_o = 1 (and error_o if flagged); then IDLE.
- Avalon handshake:
  - write/read, address and writedata are held stable while waitrequest = 1.
  - A transfer completes on the cycle where the command is high and waitrequest = 0.
  - The next command is issued the following cycle; read and write are never high together.
- Errors:
  - A verify mismatch or a timeout (RD_TIMEOUT cycles with no readdatavalid) sets the error flag, skips EN and goes to DONE.
  - The matcher is left disabled.
- Latency with waitrequest = 0, PAT_WIDTH = 3, enable_after = 1, req seen at cycle 0:
  - DIS at cycle 1, WR at 2-4, EN at 5, done_o at 6 (without verify).
  - With verify: VFY reads at 5-7, EN at 8, done_o at 9.

Optional Feature:
- Macro: PATTERN_LOADER_VERIFY_EN.
- Defined: VFY state, readback compare and timeout counter are built in.
- Undefined: WR goes directly to EN/DONE, read is tied to 0, and error_o is tied to 0.

Decomposition:
- Package pattern_loader_pkg holds:
  - state enum (IDLE, DIS, WR, VFY, EN, DONE);
  - CTRL_ADDR = 0 and ENABLE_BIT = 0;
  - a function returning pattern word k from the latched pattern.
- No sub-module: FSM, word counter and timeout counter live in one module.

Test Plan:
- Basic load: waitrequest = 0, pattern words 0x41424344 / 0x45464748 / 0x494A4B4C, enable_after = 1 -> writes (0x0, 0), (0x1, 0x41424344), (0x2, 0x45464748), (0x3, 0x494A4B4C), (0x0, 1); done_o at the cycle counts given above; slave wrken_o = 1 afterwards.
- Backpressure: waitrequest high for 3 cycles on every transfer -> command, address and data held stable; each write seen exactly once; done_o 3 cycles per transfer later than the basic case.
- enable_after = 0 -> no second write to 0x0; slave wrken_o stays 0; done_o pulses with error_o = 0.
- Verify fail (VERIFY_EN defined): slave model corrupts readdata of address 0x2 -> error_o and done_o pulse together; no enable write.
- Read timeout (VERIFY_EN defined): readdatavalid never asserted -> error_o after RD_TIMEOUT cycles.
- Reset mid-WR: assert rst_i during the write to 0x2 -> write and busy_o drop immediately; load_req_i held through reset -> a fresh full sequence starts from DIS after release.
- Request while busy: pulse load_req_i with a new pattern during WR -> ignored; only the first pattern is written.
